// File: rtl/alarm_pkg.sv
// Shared encodings and field widths for the alarm sequencer.
package alarm_pkg;

    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;
    localparam int SEC_W    = 6;
    localparam int SNOOZE_W = 9;
    localparam int MS_W     = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_e;

endpackage

// File: rtl/beep_pattern_gen.sv
// Buzzer on/off cadence, advanced by the 1 ms tick while the alarm rings.
module beep_pattern_gen
    import alarm_pkg::*;
#(
    parameter int unsigned BEEP_ON_MS  = 200,
    parameter int unsigned BEEP_OFF_MS = 300
) (
    input  logic MCLK,
    input  logic RESET_IN,
    input  logic START,
    input  logic RUN,
    input  logic TICK_1MS,
    output logic BEEP
);

    localparam logic [MS_W-1:0] ON_L  = MS_W'(BEEP_ON_MS);
    localparam logic [MS_W-1:0] OFF_L = MS_W'(BEEP_OFF_MS);

    logic            on_q, on_d;
    logic [MS_W-1:0] ms_q, ms_d, ms_inc;

    assign ms_inc = ms_q + MS_W'(1);

    // START wins over a coincident tick so the first ON phase is full length
    always_comb begin
        on_d = on_q;
        ms_d = ms_q;
        if (START) begin
            on_d = 1'b1;
            ms_d = '0;
        end else if (!RUN) begin
            on_d = 1'b0;
            ms_d = '0;
        end else if (TICK_1MS) begin
            if (on_q && ms_inc == ON_L) begin
                on_d = 1'b0;
                ms_d = '0;
            end else if (!on_q && ms_inc == OFF_L) begin
                on_d = 1'b1;
                ms_d = '0;
            end else begin
                ms_d = ms_inc;
            end
        end
    end

    always_ff @(posedge MCLK or negedge RESET_IN) begin
        if (!RESET_IN) begin
            on_q <= 1'b0;
            ms_q <= '0;
        end else begin
            on_q <= on_d;
            ms_q <= ms_d;
        end
    end

    assign BEEP = on_q;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencer: match detection, ring/snooze/stop/timeout FSM and buzzer drive.
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_SEC       = 300,
    parameter int unsigned RING_TIMEOUT_SEC = 60,
    parameter int unsigned MAX_SNOOZE       = 3,
    parameter int unsigned BEEP_ON_MS       = 200,
    parameter int unsigned BEEP_OFF_MS      = 300
) (
    input  logic                MCLK,
    input  logic                RESET_IN,
    input  logic                TICK_1MS,
    input  logic                TICK_1S,
    input  logic [HOUR_W-1:0]   CUR_HOUR,
    input  logic [MIN_W-1:0]    CUR_MIN,
    input  logic [SEC_W-1:0]    CUR_SEC,
    input  logic [HOUR_W-1:0]   ALM_HOUR,
    input  logic [MIN_W-1:0]    ALM_MIN,
    input  logic                ALM_EN,
    input  logic                BTN_SNOOZE,
    input  logic                BTN_STOP,
    output logic                BUZZER,
    output logic                RINGING,
    output logic [1:0]          STATE,
    output logic [SNOOZE_W-1:0] SNOOZE_LEFT
);

    localparam logic [SNOOZE_W-1:0] SN_L  = SNOOZE_W'(SNOOZE_SEC);
    localparam logic [7:0]          TO_L  = 8'(RING_TIMEOUT_SEC);
    localparam logic [7:0]          MAX_L = 8'(MAX_SNOOZE);

    state_e              state_q, state_d;
    logic [SNOOZE_W-1:0] left_q, left_d;
    logic [7:0]          ring_q, ring_d, ring_inc;
    logic [7:0]          scnt_q, scnt_d;
    logic                match, match_q, trig;
    logic                ringing_q;
    logic                beep_start, beep_run;

    assign match = (CUR_HOUR == ALM_HOUR) && (CUR_MIN == ALM_MIN)
                && (CUR_SEC == '0);
    // Edge-only trigger: enabling or stopping inside the matching second never re-rings
    assign trig     = match & ~match_q;
    assign ring_inc = ring_q + 8'd1;

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        ring_d  = ring_q;
        scnt_d  = scnt_q;
        if (!ALM_EN) begin
            state_d = ST_IDLE;
            left_d  = '0;
            scnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (trig) begin
                        state_d = ST_RINGING;
                        ring_d  = '0;
                    end
                end
                ST_RINGING: begin
                    if (BTN_STOP || (BTN_SNOOZE && scnt_q >= MAX_L)) begin
                        state_d = ST_ARMED;
                        scnt_d  = '0;
                    end else if (BTN_SNOOZE) begin
                        state_d = ST_SNOOZE;
                        left_d  = SN_L;
                        scnt_d  = scnt_q + 8'd1;
                    end else if (TICK_1S) begin
                        ring_d = ring_inc;
                        if (ring_inc == TO_L) begin
                            state_d = ST_ARMED;
                            scnt_d  = '0;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (BTN_STOP) begin
                        state_d = ST_ARMED;
                        scnt_d  = '0;
                        left_d  = '0;
                    end else if (TICK_1S) begin
                        left_d = left_q - SNOOZE_W'(1);
                        if (left_q == SNOOZE_W'(1)) begin
                            state_d = ST_RINGING;
                            ring_d  = '0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign beep_run   = (state_d == ST_RINGING);
    assign beep_start = beep_run && (state_q != ST_RINGING);

    always_ff @(posedge MCLK or negedge RESET_IN) begin
        if (!RESET_IN) begin
            state_q   <= ST_IDLE;
            left_q    <= '0;
            ring_q    <= '0;
            scnt_q    <= '0;
            match_q   <= 1'b0;
            ringing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            left_q    <= left_d;
            ring_q    <= ring_d;
            scnt_q    <= scnt_d;
            match_q   <= match;
            ringing_q <= beep_run;
        end
    end

    beep_pattern_gen #(
        .BEEP_ON_MS  (BEEP_ON_MS),
        .BEEP_OFF_MS (BEEP_OFF_MS)
    ) u_beep (
        .MCLK     (MCLK),
        .RESET_IN (RESET_IN),
        .START    (beep_start),
        .RUN      (beep_run),
        .TICK_1MS (TICK_1MS),
        .BEEP     (BUZZER)
    );

    assign RINGING     = ringing_q;
    assign STATE       = state_q;
    assign SNOOZE_LEFT = left_q;

endmodule

// File: doc/alarm_ring_ctrl.md
Name: alarm_ring_ctrl

Overview:
Alarm sequencer for the alarm clock. Consumes the single-cycle tick enables from the clock divider (1 ms, 1 s) and the current and alarm times. Decides when the alarm fires and runs ring, snooze, stop and timeout. Drives the buzzer with a 1 ms-resolution on/off beep pattern and exports state for the 7-seg/LED display logic.

Parameters:
SNOOZE_SEC, 300, snooze length in seconds (1..511)
RING_TIMEOUT_SEC, 60, auto-stop after this many seconds of ringing (1..255)
MAX_SNOOZE, 3, snoozes allowed per alarm event; a further SNOOZE acts as STOP
BEEP_ON_MS, 200, buzzer-on phase length in ms (1..1023)
BEEP_OFF_MS, 300, buzzer-off phase length in ms (1..1023)

Ports:
MCLK  in  1  system clock, 50 MHz
RESET_IN  in  1  asynchronous, active-low reset
TICK_1MS  in  1  one-MCLK-cycle pulse every 1 ms
TICK_1S  in  1  one-MCLK-cycle pulse every 1 s; CUR_* are stable except in the cycle after it
CUR_HOUR  in  5  current hour, 0..23
CUR_MIN  in  6  current minute, 0..59
CUR_SEC  in  6  current second, 0..59
ALM_HOUR  in  5  alarm hour
ALM_MIN  in  6  alarm minute
ALM_EN  in  1  alarm enable (level)
BTN_SNOOZE  in  1  debounced single-cycle press pulse
BTN_STOP  in  1  debounced single-cycle press pulse
BUZZER  out  1  buzzer drive, registered
RINGING  out  1  high in RINGING state
STATE  out  2  IDLE=0, ARMED=1, RINGING=2, SNOOZE=3
SNOOZE_LEFT  out  9  seconds remaining in SNOOZE; 0 in all other states

Behaviour:
- Reset (RESET_IN=0, async): state IDLE; BUZZER, RINGING, SNOOZE_LEFT, ring-second counter, snooze count, beep counters and match_d all 0. Reset mid-ring silences the buzzer immediately.
- All outputs are registered. A state change takes effect in the cycle after the causing input.
- Match: match = (CUR_HOUR==ALM_HOUR && CUR_MIN==ALM_MIN && CUR_SEC==0).
  - match_d is registered every cycle in every state.
  - trig = match & ~match_d, a rising edge only.
  - Consequence: enabling the alarm, or pressing STOP, during the matching second does not retrigger.
- Priority, highest first:
  1. ALM_EN=0 -> IDLE from any state; clear snooze count and SNOOZE_LEFT; BUZZER 0.
  2. BTN_STOP.
  3. BTN_SNOOZE.
  4. Tick events.
- IDLE: ALM_EN=1 -> ARMED.
- ARMED: trig -> RINGING. On entry, clear the ring-second counter and restart the beep pattern in its ON phase.
- RINGING:
  - BTN_STOP -> ARMED; snooze count := 0.
  - BTN_SNOOZE with snooze count < MAX_SNOOZE -> SNOOZE; SNOOZE_LEFT := SNOOZE_SEC; snooze count +1.
  - BTN_SNOOZE with snooze count == MAX_SNOOZE -> handled as STOP.
  - TICK_1S increments the ring-second counter. When it reaches RING_TIMEOUT_SEC -> ARMED; snooze count := 0.
  - STOP and SNOOZE in the same cycle: STOP wins.
- SNOOZE:
  - TICK_1S decrements SNOOZE_LEFT. On the tick where it goes 1->0 -> RINGING, with the same entry actions as from ARMED.
  - BTN_STOP -> ARMED; snooze count := 0. BTN_SNOOZE is ignored.
  - trig in SNOOZE is ignored.
- Beep pattern: only TICK_1MS advances it; ms counter 10 bits.
  - Phase ON lasts BEEP_ON_MS ticks with BUZZER=1; phase OFF lasts BEEP_OFF_MS ticks with BUZZER=0; then repeat.
  - BUZZER=1 in the first cycle of RINGING, i.e. the same cycle RINGING=1.
  - BUZZER=0 in every non-RINGING state.
- Tick coincidences: TICK_1S and TICK_1MS may be high in the same cycle, and both are processed. A BTN event in the same cycle as a tick is resolved by the priority order above.

Decomposition:
- alarm_pkg: STATE encoding constants (ST_IDLE, ST_ARMED, ST_RINGING, ST_SNOOZE), time field widths (HOUR_W=5, MIN_W=6, SEC_W=6), SNOOZE_W=9, MS_W=10.
- Sub-module beep_pattern_gen:
  - ports MCLK, RESET_IN, START (restart in ON phase), RUN, TICK_1MS, BEEP;
  - parameters BEEP_ON_MS, BEEP_OFF_MS.
- The main FSM, counters and match logic stay in alarm_ring_ctrl.

Test Plan:
(Sim params: SNOOZE_SEC=3, RING_TIMEOUT_SEC=5, MAX_SNOOZE=2, BEEP_ON_MS=2, BEEP_OFF_MS=3.)
- Alarm 07:30, ALM_EN=1, time steps 07:29:59 -> 07:30:00 -> STATE goes 1->2 one cycle after CUR_SEC=0. BUZZER pattern over TICK_1MS: 1,1,0,0,0,1,...
- RINGING with no button for 5 TICK_1S -> STATE=1 on the 5th tick, BUZZER=0. Remaining seconds of 07:30:xx cause no retrigger.
- SNOOZE press -> STATE=3, SNOOZE_LEFT=3; three TICK_1S -> 2,1, then STATE=2. Second SNOOZE -> STATE=3. Third SNOOZE -> STATE=1.
- BTN_STOP and BTN_SNOOZE in the same cycle during RINGING -> STATE=1, SNOOZE_LEFT=0. STOP at 07:30:00 -> no re-ring.
- ALM_EN dropped during SNOOZE (SNOOZE_LEFT=2) -> STATE=0, SNOOZE_LEFT=0. Re-enable -> STATE=1.
- RESET_IN pulled low between clock edges while RINGING -> BUZZER, RINGING and STATE go to 0 immediately (async), before the next MCLK edge.
